tx_holding_fifo: RTL

Parametrised successor to the UART transmit load/holding register. It buffers CPU writes (CSn/WE strobe) in a DEPTH-entry FIFO instead of a single register. It hands words to the transmit shifter with a start/done handshake, supporting back-to-back frames with no idle gap. It also masks each word to the runtime data-bit count and flags overruns.

---
 rtl/uart_tx_pkg.sv | 33 +++
 rtl/tx_fifo_mem.sv | 36 +++
 rtl/tx_holding_fifo.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_pkg
// Shared constants and helpers for the UART transmit holding FIFO.
//   MIN_BITS   : smallest character width the shifter supports
//   MAX_DATA_W : widest character any instance may be built with
//   clamp_bits : folds the runtime data-bit setting into [min_bits, data_w]
//   mask_char  : zeroes every bit of a word at or above the effective width
// ---------------------------------------------------------------------------
package uart_tx_pkg;

   localparam int MIN_BITS   = 5;
   localparam int MAX_DATA_W = 16;

   function automatic int clamp_bits(input logic [3:0] dbits,
                                     input int         data_w,
                                     input int         min_bits);
      int b;
      b = int'(dbits);
      if (b < min_bits) b = min_bits;
      if (b > data_w)   b = data_w;
      return b;
   endfunction

   function automatic logic [MAX_DATA_W-1:0] mask_char(input logic [MAX_DATA_W-1:0] word,
                                                       input int                    eff);
      logic [MAX_DATA_W-1:0] m;
      for (int i = 0; i < MAX_DATA_W; i++) begin
         m[i] = (i < eff) ? word[i] : 1'b0;
      end
      return m;
   endfunction

endpackage

// File: rtl/tx_fifo_mem.sv
// ---------------------------------------------------------------------------
// tx_fifo_mem
// DEPTH x DATA_W storage for the transmit holding FIFO. One synchronous
// write port, one combinational read port. No reset: occupancy is tracked
// by the parent, so stale contents are never observed.
//   clk     : system clock
//   wr_en   : write wr_data into entry wr_ptr at the rising edge
//   wr_ptr  : write address
//   wr_data : word to store
//   rd_ptr  : read address
//   rd_data : entry at rd_ptr (combinational)
// ---------------------------------------------------------------------------
module tx_fifo_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [PTR_W-1:0]  wr_ptr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [PTR_W-1:0]  rd_ptr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/tx_holding_fifo.sv
// ---------------------------------------------------------------------------
// tx_holding_fifo
// Buffers CPU writes for the UART transmitter and hands them to the shifter
// with a start/done handshake, allowing back-to-back frames.
//   clk, rst  : clock, synchronous active-high reset
//   CSn, WE   : CPU write strobe; a load happens every cycle WE=1 and CSn=0
//   data_in   : character written by the CPU
//   dbits     : runtime data-bit count used to mask the outgoing character
//   done      : shifter finished the current character (one-cycle pulse)
//   ovf_clr   : clears the sticky overflow flag
//   data_out  : masked character owned by the shifter
//   shifting  : shifter currently owns data_out
//   start     : one-cycle pulse, new character on data_out
//   txready   : FIFO can accept a write
//   empty     : no pending entries
//   level     : pending entries, not counting the word in data_out
//   overflow  : sticky, a write was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module tx_holding_fifo #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 4,
   parameter int MIN_BITS = uart_tx_pkg::MIN_BITS,
   localparam int CNT_W   = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              CSn,
   input  logic              WE,
   input  logic [DATA_W-1:0] data_in,
   input  logic [3:0]        dbits,
   input  logic              done,
   input  logic              ovf_clr,
   output logic [DATA_W-1:0] data_out,
   output logic              shifting,
   output logic              start,
   output logic              txready,
   output logic              empty,
   output logic [CNT_W-1:0]  level,
   output logic              overflow
);

   import uart_tx_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  level_q, level_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              shifting_q, shifting_d;
   logic              start_q, start_d;
   logic              overflow_q, overflow_d;

   logic              load, pop, push, drop, full;
   logic [DATA_W-1:0] head;
   logic [DATA_W-1:0] head_masked;
   int                eff;

   tx_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_ptr  (wr_ptr_q),
      .wr_data (data_in),
      .rd_ptr  (rd_ptr_q),
      .rd_data (head)
   );

   // Full/empty come from the level counter, never from pointer equality.
   // A pop in the same cycle frees a slot, so a write into a full FIFO is
   // still taken when the shifter is draining.
   always_comb begin
      load        = WE & ~CSn;
      full        = (level_q == CNT_W'(DEPTH));
      pop         = (level_q != '0) && (!shifting_q || done);
      push        = load && (!full || pop);
      drop        = load && full && !pop;
      eff         = clamp_bits(dbits, DATA_W, MIN_BITS);
      head_masked = DATA_W'(mask_char(MAX_DATA_W'(head), eff));

      wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      level_d = level_q;
      if (push && !pop) level_d = level_q + CNT_W'(1);
      else if (pop && !push) level_d = level_q - CNT_W'(1);

      // dbits is only consulted at pop, so data_out is frozen mid-frame.
      data_out_d = pop ? head_masked : data_out_q;
      start_d    = pop;

      // A done with nothing pending releases the shifter; with data pending
      // the next word loads on the same edge and shifting never drops.
      shifting_d = shifting_q;
      if (pop) shifting_d = 1'b1;
      else if (done) shifting_d = 1'b0;

      overflow_d = overflow_q;
      if (drop) overflow_d = 1'b1;
      else if (ovf_clr) overflow_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         data_out_q <= '0;
         shifting_q <= 1'b0;
         start_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         data_out_q <= data_out_d;
         shifting_q <= shifting_d;
         start_q    <= start_d;
         overflow_q <= overflow_d;
      end
   end

   assign data_out = data_out_q;
   assign shifting = shifting_q;
   assign start    = start_q;
   assign level    = level_q;
   assign overflow = overflow_q;
   assign txready  = (level_q < CNT_W'(DEPTH));
   assign empty    = (level_q == '0);

endmodule
